// File: rtl/uop_sequencer.sv
// uop_sequencer
//   Microprogram store and sequencer for the curve arithmetic datapath.
//   One writable micro-op RAM holds 2^SEL_W programs, each in a fixed slot of
//   2^(PC_W-SEL_W) words. A start pulse walks the selected slot and hands one
//   micro-op at a time to the executor over valid/ack, stopping on the RDY
//   opcode (done) or at the end of the slot (done + sticky err).
//
//   Optional feature: define UOP_SEQ_SKIP_EN to let the sequencer evaluate the
//   condition field itself and drop words whose condition is false.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data   RAM write port (honoured only while idle)
//   start, prog_sel           run request and program number (honoured only while idle)
//   uop_valid, uop_data       micro-op to executor
//   uop_ack, flags            executor accept and condition flags (sampled on ack)
//   busy, done, err           status: not idle / one-cycle completion / slot overrun
module uop_sequencer #(
    parameter int UOP_W  = 20,
    parameter int PC_W   = 6,
    parameter int SEL_W  = 2,
    parameter int OPC_W  = 4,
    parameter int EXEC_W = 2,
    parameter logic [OPC_W-1:0] OPCODE_RDY = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PC_W-1:0]  wr_addr,
    input  logic [UOP_W-1:0] wr_data,
    input  logic             start,
    input  logic [SEL_W-1:0] prog_sel,
    output logic             uop_valid,
    output logic [UOP_W-1:0] uop_data,
    input  logic             uop_ack,
    input  logic [1:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int OFF_W = PC_W - SEL_W;
    localparam int DEPTH = 2 ** PC_W;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [1:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic [UOP_W-1:0] uop_q, uop_d;
    logic [UOP_W-1:0] rd_q, rd_d;
    logic [UOP_W-1:0] mem [DEPTH];

    logic             wr_ok;
    logic             slot_end;
    logic             is_rdy;
    logic             cond_ok;
    logic [UOP_W-1:0] issue_word;

    assign wr_ok    = wr_en && (state_q == S_IDLE);
    assign slot_end = &pc_q[OFF_W-1:0];
    assign is_rdy   = (rd_q[UOP_W-1 -: OPC_W] == OPCODE_RDY);

`ifdef UOP_SEQ_SKIP_EN
    logic [EXEC_W-1:0] cond;
    assign cond = rd_q[EXEC_W-1:0];

    always_comb begin
        cond_ok = 1'b1;
        if (cond == EXEC_W'(1))      cond_ok = flags_q[0];
        else if (cond == EXEC_W'(2)) cond_ok = !flags_q[0];
        else if (cond == EXEC_W'(3)) cond_ok = flags_q[1];
    end

    // The condition has already been resolved here, so the executor sees "always".
    assign issue_word = {rd_q[UOP_W-1:EXEC_W], {EXEC_W{1'b0}}};
`else
    // Executor resolves conditions itself; flags_q is kept for observability only.
    logic unused_flags;
    assign unused_flags = ^flags_q;
    assign cond_ok      = 1'b1;
    assign issue_word   = rd_q;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        err_d   = err_q;
        uop_d   = uop_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = {prog_sel, {OFF_W{1'b0}}};
                    err_d   = 1'b0;
                    flags_d = 2'b00;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (is_rdy) begin
                    state_d = S_DONE;
                end else if (!cond_ok) begin
                    // Skipped word: stay in FETCH and read the next one.
                    pc_d = pc_q + PC_W'(1);
                    if (slot_end) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    uop_d   = issue_word;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (uop_ack) begin
                    flags_d = flags;
                    pc_d    = pc_q + PC_W'(1);
                    if (slot_end) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read address follows pc_d so the word is waiting in rd_q during FETCH.
    // A write to the same address in the same cycle is forwarded (write-first),
    // which is what lets wr_en+start land the write before the first fetch.
    always_comb begin
        rd_d = mem[pc_d];
        if (wr_ok && (wr_addr == pc_d)) rd_d = wr_data;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            flags_q <= 2'b00;
            err_q   <= 1'b0;
            uop_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            uop_q   <= uop_d;
            rd_q    <= rd_d;
        end
    end

    assign uop_valid = (state_q == S_ISSUE);
    assign uop_data  = uop_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
endmodule
